// File: rtl/sound_arbiter.sv
// sound_arbiter: shares the two tone channels between the background music
// pair and NUM_REQ one-shot sound effects (fixed priority, index 0 highest).
// A silence gap is inserted on every game_state change, and mute forces
// silence on both channels without disturbing the internal timing.
//
// Optional feature macro: SOUND_ARBITER_CHIRP_EN
//   defined     -> second half of each effect plays one octave up
//                  (SILENT when the doubled tone would overflow 26 bits)
//   not defined -> the effect tone is constant for its whole length
//
// Request handshake: req[i] is a single-cycle pulse with no ready/back-pressure.
// It is never lost except by reset: it either wins arbitration immediately
// or is parked in pending[i] until grant[i] pulses for it.

module sound_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SFX_CYCLES = 2500000,
  parameter int GAP_CYCLES = 5000000,
  parameter int SILENT     = 50000000,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mute,
  input  logic [3:0]            game_state,
  input  logic [25:0]           bgm_l,
  input  logic [25:0]           bgm_r,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [26*NUM_REQ-1:0] req_freq,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  sfx_busy,
  output logic [ID_W-1:0]       cur_id,
  output logic [25:0]           freqL,
  output logic [25:0]           freqR
);

  localparam logic [25:0] SILENT_F = 26'(SILENT);
  localparam logic [31:0] SFX_LOAD = 32'(SFX_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES);
`ifdef SOUND_ARBITER_CHIRP_EN
  localparam logic [31:0] SFX_HALF = 32'(SFX_CYCLES / 2);
`endif

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0] pending;
  logic [25:0]        sfx_freq;
  logic [31:0]        sfx_cnt;
  logic [31:0]        gap_cnt;
  logic [3:0]         prev_state;

  // ---------------------------------------------------------------------
  // Next-state values; outputs are registered from these so that an
  // effect or a gap is visible on the very edge that starts it.
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0] eff;
  logic [NUM_REQ-1:0] win_vec;
  logic [ID_W-1:0]    win_id;
  logic [25:0]        win_freq;
  logic               any_req;
  logic               do_grant;

  logic [NUM_REQ-1:0] pending_next;
  logic [NUM_REQ-1:0] grant_next;
  logic               busy_next;
  logic [ID_W-1:0]    id_next;
  logic [25:0]        sfx_freq_next;
  logic [31:0]        sfx_cnt_next;

  logic               state_change;
  logic [31:0]        gap_cnt_next;

  logic [25:0]        tone_next;
  logic [25:0]        freq_l_next;
  logic [25:0]        freq_r_next;

  // Effective request set: live pulses plus requests parked while busy.
  assign eff     = pending | req;
  assign any_req = |eff;

  // Fixed-priority pick: isolate the lowest set bit of eff.
  assign win_vec = eff & (~eff + 1'b1);

  // Index and tone of the winner, taken from its one-hot position.
  always_comb begin
    win_id   = '0;
    win_freq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_vec[i]) begin
        win_id   = ID_W'(i);
        win_freq = req_freq[26*i +: 26];
      end
    end
  end

  // A winner starts when idle, preempts or retriggers when its index is
  // not lower in priority than the playing one, or follows on back-to-back
  // when the current effect is on its last cycle.
  assign do_grant = any_req &&
                    (!sfx_busy || (win_id <= cur_id) || (sfx_cnt == 32'd0));

  // Effect sequencing: grant/relatch/restart, or count down to idle.
  always_comb begin
    pending_next  = eff;
    grant_next    = '0;
    busy_next     = sfx_busy;
    id_next       = cur_id;
    sfx_freq_next = sfx_freq;
    sfx_cnt_next  = sfx_cnt;
    if (do_grant) begin
      // The preempted effect is simply dropped; everyone else who asked
      // stays parked for later.
      pending_next  = eff & ~win_vec;
      grant_next    = win_vec;
      busy_next     = 1'b1;
      id_next       = win_id;
      sfx_freq_next = win_freq;
      sfx_cnt_next  = SFX_LOAD;
    end else if (sfx_busy) begin
      if (sfx_cnt == 32'd0) begin
        busy_next = 1'b0;
      end else begin
        sfx_cnt_next = sfx_cnt - 32'd1;
      end
    end
  end

  // Silence gap: (re)load on any game_state change, otherwise count down.
  assign state_change = (game_state != prev_state);

  always_comb begin
    gap_cnt_next = gap_cnt;
    if (state_change) begin
      gap_cnt_next = GAP_LOAD;
    end else if (gap_cnt != 32'd0) begin
      gap_cnt_next = gap_cnt - 32'd1;
    end
  end

  // Effect tone as heard, including the optional octave-up second half.
  always_comb begin
    tone_next = sfx_freq_next;
`ifdef SOUND_ARBITER_CHIRP_EN
    if (sfx_cnt_next < SFX_HALF) begin
      if (sfx_freq_next[25]) begin
        tone_next = SILENT_F;
      end else begin
        tone_next = {sfx_freq_next[24:0], 1'b0};
      end
    end
`endif
  end

  // Channel source selection: mute, then effect, then gap, then music.
  always_comb begin
    freq_l_next = bgm_l;
    freq_r_next = bgm_r;
    if (mute) begin
      freq_l_next = SILENT_F;
      freq_r_next = SILENT_F;
    end else if (busy_next) begin
      freq_l_next = tone_next;
      freq_r_next = tone_next;
    end else if (gap_cnt_next != 32'd0) begin
      freq_l_next = SILENT_F;
      freq_r_next = SILENT_F;
    end
  end

  // State and output registers; reset aborts any effect, gap or request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      grant      <= '0;
      sfx_busy   <= 1'b0;
      cur_id     <= '0;
      sfx_freq   <= '0;
      sfx_cnt    <= '0;
      gap_cnt    <= '0;
      prev_state <= '0;
      freqL      <= SILENT_F;
      freqR      <= SILENT_F;
    end else begin
      pending    <= pending_next;
      grant      <= grant_next;
      sfx_busy   <= busy_next;
      cur_id     <= id_next;
      sfx_freq   <= sfx_freq_next;
      sfx_cnt    <= sfx_cnt_next;
      gap_cnt    <= gap_cnt_next;
      prev_state <= game_state;
      freqL      <= freq_l_next;
      freqR      <= freq_r_next;
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed bench for sound_arbiter with short effect and
// gap lengths. Expected output tuples are queued as each step is driven and
// compared after the following clock edge.

module tb_sound_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SFX_C   = 10;
  localparam int GAP_C   = 6;
  localparam int S       = 50000000;
  localparam int W       = 26 + 26 + 1 + 4 + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  mute = 1'b0;
  logic [3:0]            game_state = 4'd0;
  logic [25:0]           bgm_l = 26'd262;
  logic [25:0]           bgm_r = 26'd330;
  logic [NUM_REQ-1:0]    req = '0;
  logic [26*NUM_REQ-1:0] req_freq = {26'd1047, 26'd880, 26'd523, 26'd440};
  logic [NUM_REQ-1:0]    grant;
  logic                  sfx_busy;
  logic [1:0]            cur_id;
  logic [25:0]           freqL;
  logic [25:0]           freqR;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  sound_arbiter #(
    .NUM_REQ(NUM_REQ),
    .SFX_CYCLES(SFX_C),
    .GAP_CYCLES(GAP_C),
    .SILENT(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mute(mute),
    .game_state(game_state),
    .bgm_l(bgm_l),
    .bgm_r(bgm_r),
    .req(req),
    .req_freq(req_freq),
    .grant(grant),
    .sfx_busy(sfx_busy),
    .cur_id(cur_id),
    .freqL(freqL),
    .freqR(freqR)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] pk(input int l, input int r, input logic b,
                                      input logic [3:0] g, input int id);
    return {26'(l), 26'(r), b, g, 2'(id)};
  endfunction

  // Pop the oldest expectation and compare against the current outputs.
  task automatic check_now(input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {freqL, freqR, sfx_busy, grant, cur_id};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: expected queue empty", tag);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        tests_failed++;
        $error("FAIL %s: got L=%0d R=%0d busy=%b grant=%b id=%0d, expected L=%0d R=%0d busy=%b grant=%b id=%0d",
               tag, got[58:33], got[32:7], got[6], got[5:2], got[1:0],
               exp[58:33], exp[32:7], exp[6], exp[5:2], exp[1:0]);
      end
    end
  endtask

  // Queue one expected tuple, advance one edge, then compare.
  task automatic cyc(input string tag, input int l, input int r, input logic b,
                     input logic [3:0] g, input int id);
    exp_q.push_back(pk(l, r, b, g, id));
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic cyc_n(input string tag, input int n, input int l, input int r,
                       input logic b, input int id);
    for (int k = 0; k < n; k++) begin
      cyc(tag, l, r, b, 4'b0000, id);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pk(S, S, 1'b0, 4'b0000, 0));
    check_now("reset");
    rst = 1'b0;

    // Idle: background music passes through
    cyc_n("bgm_idle", 3, 262, 330, 1'b0, 0);

    // Single effect from requester 2, exactly SFX_C cycles long
    req = 4'b0100;
    cyc("sfx2_grant", 880, 880, 1'b1, 4'b0100, 2);
    req = 4'b0000;
    cyc_n("sfx2_play", 9, 880, 880, 1'b1, 2);
    cyc_n("sfx2_done", 2, 262, 330, 1'b0, 2);

    // Preemption by 0 while 2 plays; 3 parked and served back-to-back
    req = 4'b0100;
    cyc("pre_grant2", 880, 880, 1'b1, 4'b0100, 2);
    req = 4'b0000;
    cyc_n("pre_play2", 2, 880, 880, 1'b1, 2);
    req = 4'b1001;
    cyc("pre_grant0", 440, 440, 1'b1, 4'b0001, 0);
    req = 4'b0000;
    cyc_n("pre_play0", 9, 440, 440, 1'b1, 0);
    cyc("pre_grant3", 1047, 1047, 1'b1, 4'b1000, 3);
    cyc_n("pre_play3", 9, 1047, 1047, 1'b1, 3);
    cyc_n("pre_bgm", 2, 262, 330, 1'b0, 3);

    // Two requests from idle on the same cycle: 1 first, then 2
    req = 4'b0110;
    cyc("dual_grant1", 523, 523, 1'b1, 4'b0010, 1);
    req = 4'b0000;
    cyc_n("dual_play1", 9, 523, 523, 1'b1, 1);
    cyc("dual_grant2", 880, 880, 1'b1, 4'b0100, 2);
    cyc_n("dual_play2", 9, 880, 880, 1'b1, 2);
    cyc("dual_bgm", 262, 330, 1'b0, 4'b0000, 2);

    // Retrigger of the playing requester restarts its full length
    req = 4'b0010;
    cyc("rtg_grant", 523, 523, 1'b1, 4'b0010, 1);
    req = 4'b0000;
    cyc_n("rtg_play_a", 3, 523, 523, 1'b1, 1);
    req = 4'b0010;
    cyc("rtg_regrant", 523, 523, 1'b1, 4'b0010, 1);
    req = 4'b0000;
    cyc_n("rtg_play_b", 9, 523, 523, 1'b1, 1);
    cyc("rtg_bgm", 262, 330, 1'b0, 4'b0000, 1);

    // Gap on state change, then new music
    game_state = 4'd2;
    bgm_l = 26'd392;
    bgm_r = 26'd494;
    cyc_n("gap_silent", 6, S, S, 1'b0, 1);
    cyc("gap_end", 392, 494, 1'b0, 4'b0000, 1);

    // Second change at gap cycle 4 reloads the full gap
    game_state = 4'd3;
    cyc_n("gap2_first", 4, S, S, 1'b0, 1);
    game_state = 4'd5;
    cyc_n("gap2_reload", 6, S, S, 1'b0, 1);
    cyc("gap2_end", 392, 494, 1'b0, 4'b0000, 1);

    // Effect during a gap; the gap expires underneath it
    game_state = 4'd6;
    cyc("gsfx_gap", S, S, 1'b0, 4'b0000, 1);
    req = 4'b0001;
    cyc("gsfx_grant", 440, 440, 1'b1, 4'b0001, 0);
    req = 4'b0000;
    cyc_n("gsfx_play", 9, 440, 440, 1'b1, 0);
    cyc("gsfx_bgm", 392, 494, 1'b0, 4'b0000, 0);

    // Mute mid-effect: silent but timing unchanged
    req = 4'b0100;
    cyc("mute_grant", 880, 880, 1'b1, 4'b0100, 2);
    req = 4'b0000;
    mute = 1'b1;
    cyc_n("mute_on", 4, S, S, 1'b1, 2);
    mute = 1'b0;
    cyc_n("mute_off", 5, 880, 880, 1'b1, 2);
    cyc("mute_bgm", 392, 494, 1'b0, 4'b0000, 2);

    // Asynchronous reset mid-effect with requester 1 pending
    req = 4'b0001;
    cyc("rst_grant0", 440, 440, 1'b1, 4'b0001, 0);
    req = 4'b0010;
    cyc("rst_pend1", 440, 440, 1'b1, 4'b0000, 0);
    req = 4'b0000;
    game_state = 4'd0;
    rst = 1'b1;
    #2;
    exp_q.push_back(pk(S, S, 1'b0, 4'b0000, 0));
    check_now("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(pk(S, S, 1'b0, 4'b0000, 0));
    check_now("rst_held");
    rst = 1'b0;
    cyc_n("rst_after", 3, 392, 494, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Sits between the BGM selector and the audio PWM driver.
- Shares the two tone channels between the background-music pair (bgm_l/bgm_r) and up to NUM_REQ one-shot sound-effect requesters, using fixed priority.
- Inserts a silence gap whenever the game state changes, and applies mute.
- Outputs are registered tone frequencies in the codebase format; 50000000 means silent.

Parameters:
- NUM_REQ, 4, number of SFX requesters; index 0 has the highest priority.
- SFX_CYCLES, 2500000, length of one effect in clk cycles; must be >=1.
- GAP_CYCLES, 5000000, silence length after a state change in clk cycles; 0 disables the gap.
- SILENT, 50000000, tone value meaning silence.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mute  in  1  forces silent outputs; internal state keeps running.
- game_state  in  4  current game FSM state.
- bgm_l  in  26  BGM left tone.
- bgm_r  in  26  BGM right tone.
- req  in  NUM_REQ  SFX request pulses, one bit per requester.
- req_freq  in  26*NUM_REQ  tone per requester; slice i is bits [26*i+25:26*i].
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a requester starts playing.
- sfx_busy  out  1  high while an effect is playing.
- cur_id  out  log2(NUM_REQ)  index of the playing effect; holds its last value when idle.
- freqL  out  26  left tone to the driver.
- freqR  out  26  right tone to the driver.

Behaviour:
- Reset (async, rst=1): freqL=freqR=SILENT; grant=0; sfx_busy=0; cur_id=0; pending=0; sfx_cnt=0; gap_cnt=0; prev_state=0.
- Request capture: eff = pending | req. A req pulse while busy sets pending[i]. pending[i] clears on grant of i.
- Arbitration: the winner is the lowest set index in eff. Evaluated every cycle.
- Start of effect (when idle): if eff!=0 at edge n, then at edge n+1:
  - grant[w]=1, sfx_busy=1, cur_id=w;
  - sfx_freq latched from req_freq slice w; sfx_cnt=SFX_CYCLES-1;
  - freqL/freqR show the effect starting this same edge (1-cycle latency).
- Preemption: while busy with id k, a winner w<k preempts.
  - Regrant, relatch, restart the count.
  - The preempted effect k is dropped, not resumed.
  - Pending bits of lower-priority requesters (index >k) are kept and served after completion.
- Retrigger: req[k] while k is playing, with no higher winner, restarts sfx_cnt, relatches the frequency, and pulses grant[k] again.
- Completion: when sfx_cnt==0 and no preemption, sfx_busy drops next edge. If eff!=0 on that edge, the next winner is granted on the same edge with no silent cycle.
- Gap: game_state != prev_state loads gap_cnt=GAP_CYCLES and updates prev_state. gap_cnt decrements to 0. A state change during a gap reloads the count.
- Output priority, registered:
  - mute -> SILENT on both channels;
  - else sfx_busy -> sfx_freq on both channels;
  - else gap_cnt!=0 -> SILENT;
  - else bgm_l/bgm_r.
- An SFX may play during a gap; the gap keeps counting underneath.
- Widths: all counters are 32-bit unsigned. Frequency paths are 26-bit with no arithmetic, except under the optional feature below.
- Reset mid-effect or mid-gap: aborts immediately to the reset values; pending requests are lost.

Optional Feature:
- Macro: SOUND_ARBITER_CHIRP_EN.
- Defined: for the second half of each effect (sfx_cnt < SFX_CYCLES/2), the output is sfx_freq<<1, one octave up. If bit 25 of sfx_freq is set (shift overflow), output SILENT instead.
- Not defined: the tone is constant for the whole effect.
- Arbitration, timing and all other outputs are identical either way.

Test Plan:
- Reset, then game_state=0, bgm_l=262, bgm_r=330, no req -> freqL=262, freqR=330 from the 2nd edge onward; sfx_busy=0.
- SFX_CYCLES=10; req[2] pulse with slice2=880 -> grant=4'b0100 for 1 cycle; freqL=freqR=880 for exactly 10 cycles, then 262/330.
- req[2] playing, then req[3] and req[0] pulse together at cycle 3 -> grant[0] next edge, 10 cycles of tone0, then grant[3] with no silent cycle, then BGM; req[2] never resumes.
- GAP_CYCLES=6; game_state 0->2 -> 6 cycles SILENT, then the new bgm values; a second change at gap cycle 4 -> 6 further SILENT cycles.
- mute=1 during an effect -> SILENT throughout; after mute=0 the remaining effect cycles play; sfx_busy timing is unaffected.
- rst asserted mid-effect with req[1] pending -> outputs SILENT and grant=0 immediately; after release, BGM only, no grant.
